kbd_ctrl: RTL and testbench

Buffered polling controller between the CPU I/O bus and the PS/2 keyboard device. A small FSM continuously polls the keyboard's status register and, whenever a character is ready, reads it and pushes it into an internal FIFO. The CPU sees a register pair in the keyboard's own format, backed by the FIFO instead of the single-byte device latch, so bursts of keystrokes are not lost. The block sits in the I/O decode path in place of the direct CPU-to-keyboard connection.

---
 rtl/kbd_ctrl.sv | 118 +++++++++++
 tb/tb_kbd_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ctrl.sv
// rtl/kbd_ctrl.sv - buffered PS/2 keyboard polling controller with CPU-side FIFO
module kbd_ctrl #(
   parameter int DEPTH_LOG2 = 4,
   parameter int POLL_GAP   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stb,
   input  logic       we,
   input  logic       addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       ack,
   output logic       irq,
   output logic       dev_stb,
   output logic       dev_we,
   output logic       dev_addr,
   output logic [7:0] dev_wdata,
   input  logic [7:0] dev_rdata,
   input  logic       dev_ack
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [7:0] GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

   typedef enum logic [1:0] {INIT, POLL, GAP, READ} state_t;

   state_t                state;
   state_t                state_nxt;
   state_t                after_acc;
   logic [7:0]            gap_cnt;
   logic                  acc_done;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  ien;
   logic                  ovf;
   logic                  ne;
   logic                  full;
   logic                  pop;
   logic                  push_req;
   logic                  push;
   logic                  ctrl_wr;
   logic                  unused_data_in;

   assign acc_done  = dev_stb & dev_ack;
   assign after_acc = (POLL_GAP == 0) ? POLL : GAP;

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (acc_done) state_nxt = after_acc;
         POLL:    if (acc_done) state_nxt = dev_rdata[0] ? READ : after_acc;
         GAP:     if (gap_cnt == GAP_LAST) state_nxt = POLL;
         READ:    if (acc_done) state_nxt = after_acc;
         default: state_nxt = INIT;
      endcase
   end

   // Device outputs are decoded from the next state so they change only on the ack edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         gap_cnt   <= 8'd0;
         dev_stb   <= 1'b0;
         dev_we    <= 1'b0;
         dev_addr  <= 1'b0;
         dev_wdata <= 8'h00;
      end else begin
         state     <= state_nxt;
         gap_cnt   <= (state == GAP && state_nxt == GAP) ? gap_cnt + 8'd1 : 8'd0;
         dev_stb   <= (state_nxt != GAP);
         dev_we    <= (state_nxt == INIT);
         dev_addr  <= (state_nxt == READ);
         dev_wdata <= 8'h00;
      end
   end

   assign ne       = (count != '0);
   assign full     = count[DEPTH_LOG2];
   assign pop      = stb & ~we & addr & ne;
   assign ctrl_wr  = stb & we & ~addr;
   assign push_req = (state == READ) & acc_done;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign push     = push_req & (~full | pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dev_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ien    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ctrl_wr) ien <= data_in[1];
         if (push_req && !push)          ovf <= 1'b1;
         else if (ctrl_wr && data_in[2]) ovf <= 1'b0;
      end
   end

   assign data_out       = addr ? (ne ? mem[rd_ptr] : 8'h00) : {5'b0, ovf, ien, ne};
   assign ack            = stb;
   assign irq            = ien & ne;
   assign unused_data_in = ^{data_in[7:3], data_in[0]};

endmodule

// File: tb/tb_kbd_ctrl.sv
// tb/tb_kbd_ctrl.sv - directed bench for kbd_ctrl with zero-wait and slow device models
module tb_kbd_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance A: depth 4, no poll gap, zero-wait device
   logic       a_rst = 1'b1, a_stb = 1'b0, a_we = 1'b0, a_addr = 1'b0;
   logic [7:0] a_din = 8'h00, a_dout;
   logic       a_ack, a_irq;
   logic       a_dev_stb, a_dev_we, a_dev_addr, a_dev_ack;
   logic [7:0] a_dev_wdata, a_dev_rdata;
   logic       a_rdy = 1'b0, a_load = 1'b0, a_init_seen = 1'b0;
   logic [7:0] a_key = 8'h00, a_val = 8'h00, a_init_data = 8'hFF;

   assign a_dev_ack   = a_dev_stb;
   assign a_dev_rdata = a_dev_addr ? a_key : {7'b0, a_rdy};

   always @(posedge clk) begin
      if (a_dev_stb && a_dev_ack && a_dev_we) begin
         a_init_seen <= 1'b1;
         a_init_data <= a_dev_wdata;
      end
      if (a_dev_stb && a_dev_ack && !a_dev_we && a_dev_addr) a_rdy <= 1'b0;
      if (a_load) begin
         a_rdy <= 1'b1;
         a_key <= a_val;
      end
   end

   kbd_ctrl #(.DEPTH_LOG2(2), .POLL_GAP(0)) dut_a (
      .clk(clk), .rst(a_rst), .stb(a_stb), .we(a_we), .addr(a_addr),
      .data_in(a_din), .data_out(a_dout), .ack(a_ack), .irq(a_irq),
      .dev_stb(a_dev_stb), .dev_we(a_dev_we), .dev_addr(a_dev_addr),
      .dev_wdata(a_dev_wdata), .dev_rdata(a_dev_rdata), .dev_ack(a_dev_ack)
   );

   // instance B: depth 16, poll gap 5, device acks on the fourth cycle of an access
   logic       b_rst = 1'b1, b_stb = 1'b0, b_we = 1'b0, b_addr = 1'b0;
   logic [7:0] b_din = 8'h00, b_dout;
   logic       b_ack, b_irq;
   logic       b_dev_stb, b_dev_we, b_dev_addr, b_dev_ack;
   logic [7:0] b_dev_wdata, b_dev_rdata;
   logic       b_rdy = 1'b0, b_load = 1'b0;
   logic [7:0] b_key = 8'h00, b_val = 8'h00;
   logic [1:0] b_cnt = 2'd0;

   assign b_dev_ack   = b_dev_stb && (b_cnt == 2'd3);
   assign b_dev_rdata = b_dev_addr ? b_key : {7'b0, b_rdy};

   always @(posedge clk) begin
      if (b_dev_stb && !b_dev_ack) b_cnt <= b_cnt + 2'd1;
      else                         b_cnt <= 2'd0;
      if (b_dev_ack && !b_dev_we && b_dev_addr) b_rdy <= 1'b0;
      if (b_load) begin
         b_rdy <= 1'b1;
         b_key <= b_val;
      end
   end

   kbd_ctrl #(.DEPTH_LOG2(4), .POLL_GAP(5)) dut_b (
      .clk(clk), .rst(b_rst), .stb(b_stb), .we(b_we), .addr(b_addr),
      .data_in(b_din), .data_out(b_dout), .ack(b_ack), .irq(b_irq),
      .dev_stb(b_dev_stb), .dev_we(b_dev_we), .dev_addr(b_dev_addr),
      .dev_wdata(b_dev_wdata), .dev_rdata(b_dev_rdata), .dev_ack(b_dev_ack)
   );

   // stimulus helpers: entered and left just after a rising edge
   task automatic send_a(input logic [7:0] k);
      a_val = k; a_load = 1'b1;
      @(posedge clk); #1; a_load = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic read_a(output logic [7:0] d);
      a_stb = 1'b1; a_we = 1'b0; a_addr = 1'b1; #1;
      d = a_dout;
      @(posedge clk); #1; a_stb = 1'b0; a_addr = 1'b0;
   endtask

   task automatic write_a(input logic [7:0] d);
      a_stb = 1'b1; a_we = 1'b1; a_addr = 1'b0; a_din = d;
      @(posedge clk); #1; a_stb = 1'b0; a_we = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_addr = 1'b0; #1;
      total++; if ({a_dev_stb, a_dev_we, a_dev_addr, a_dev_wdata, a_irq} !== 12'h000) begin
         bad++; $display("FAIL reset_outputs: got %h want 000", {a_dev_stb, a_dev_we, a_dev_addr, a_dev_wdata, a_irq}); end
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", a_dout); end
      a_addr = 1'b1; #1;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", a_dout); end
      a_addr = 1'b0;
      @(posedge clk); #1; a_rst = 1'b0; b_rst = 1'b0;
      @(posedge clk); #1;
      total++; if ({a_dev_stb, a_dev_we, a_dev_addr, a_dev_wdata} !== 11'h600) begin
         bad++; $display("FAIL init_access: got %h want 600", {a_dev_stb, a_dev_we, a_dev_addr, a_dev_wdata}); end
      @(posedge clk); #1;
      total++; if ({a_init_seen, a_init_data} !== 9'h100) begin
         bad++; $display("FAIL init_write: got %h want 100", {a_init_seen, a_init_data}); end
      total++; if ({a_dev_stb, a_dev_we, a_dev_addr} !== 3'b100) begin
         bad++; $display("FAIL poll_access: got %b want 100", {a_dev_stb, a_dev_we, a_dev_addr}); end
      @(posedge clk); #1;
      total++; if ({a_dev_stb, a_dev_we, a_dev_addr} !== 3'b100) begin
         bad++; $display("FAIL poll_repeat: got %b want 100", {a_dev_stb, a_dev_we, a_dev_addr}); end
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL idle_status: got %h want 00", a_dout); end
   endtask

   task automatic test_char;
      a_val = 8'h1C; a_load = 1'b1;
      @(posedge clk); #1; a_load = 1'b0;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL ne_edge1: got %h want 00", a_dout); end
      @(posedge clk); #1;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL ne_edge2: got %h want 00", a_dout); end
      @(posedge clk); #1;
      total++; if (a_dout !== 8'h01) begin bad++; $display("FAIL ne_edge3: got %h want 01", a_dout); end
      a_stb = 1'b1; a_addr = 1'b1; #1;
      total++; if (a_ack !== 1'b1) begin bad++; $display("FAIL cpu_ack: got %b want 1", a_ack); end
      total++; if (a_dout !== 8'h1C) begin bad++; $display("FAIL data_1c: got %h want 1c", a_dout); end
      @(posedge clk); #1; a_stb = 1'b0; a_addr = 1'b0; #1;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL status_after_pop: got %h want 00", a_dout); end
   endtask

   task automatic test_irq;
      write_a(8'h02);
      a_addr = 1'b0; #1;
      total++; if ({a_dout, a_irq} !== 9'h004) begin bad++; $display("FAIL ien_set: got %h want 004", {a_dout, a_irq}); end
      send_a(8'h55);
      total++; if ({a_dout, a_irq} !== 9'h007) begin bad++; $display("FAIL irq_rise: got %h want 007", {a_dout, a_irq}); end
      a_stb = 1'b1; a_addr = 1'b1; #1;
      total++; if ({a_dout, a_irq} !== 9'h0AB) begin bad++; $display("FAIL irq_pop_cycle: got %h want 0ab", {a_dout, a_irq}); end
      @(posedge clk); #1; a_stb = 1'b0; a_addr = 1'b0;
      total++; if (a_irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", a_irq); end
      write_a(8'h00);
   endtask

   task automatic test_overflow;
      logic [7:0] keys [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [7:0] d;
      for (int i = 0; i < 6; i++) send_a(keys[i]);
      a_addr = 1'b0; #1;
      total++; if (a_dout !== 8'h05) begin bad++; $display("FAIL ovf_status: got %h want 05", a_dout); end
      for (int i = 0; i < 4; i++) begin
         read_a(d);
         total++; if (d !== keys[i]) begin bad++; $display("FAIL ovf_order%0d: got %h want %h", i, d, keys[i]); end
      end
      #1;
      total++; if (a_dout !== 8'h04) begin bad++; $display("FAIL ovf_drained: got %h want 04", a_dout); end
      read_a(d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL empty_read: got %h want 00", d); end
      #1;
      total++; if (a_dout !== 8'h04) begin bad++; $display("FAIL empty_read_flags: got %h want 04", a_dout); end
      write_a(8'h04);
      #1;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL ovf_clear: got %h want 00", a_dout); end
   endtask

   task automatic test_full_push_pop;
      logic [7:0] exp [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      logic [7:0] d;
      for (int i = 0; i < 4; i++) send_a(8'hA0 + 8'(i));
      a_val = 8'hA4; a_load = 1'b1;
      @(posedge clk); #1; a_load = 1'b0;
      @(posedge clk); #1;
      read_a(d);
      total++; if (d !== 8'hA0) begin bad++; $display("FAIL full_pp_head: got %h want a0", d); end
      #1;
      total++; if (a_dout !== 8'h01) begin bad++; $display("FAIL full_pp_status: got %h want 01", a_dout); end
      for (int i = 0; i < 4; i++) begin
         read_a(d);
         total++; if (d !== exp[i]) begin bad++; $display("FAIL wrap_order%0d: got %h want %h", i, d, exp[i]); end
      end
      #1;
      total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL full_pp_empty: got %h want 00", a_dout); end
   endtask

   task automatic test_empty_push_pop;
      logic [7:0] d;
      a_val = 8'h77; a_load = 1'b1;
      @(posedge clk); #1; a_load = 1'b0;
      @(posedge clk); #1;
      read_a(d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL empty_pp_read: got %h want 00", d); end
      #1;
      total++; if (a_dout !== 8'h01) begin bad++; $display("FAIL empty_pp_count: got %h want 01", a_dout); end
      read_a(d);
      total++; if (d !== 8'h77) begin bad++; $display("FAIL empty_pp_data: got %h want 77", d); end
   endtask

   task automatic test_back_to_back_delayed;
      int n, hi, lo;
      logic ok;
      n = 0;
      @(negedge clk);
      while (b_dev_stb !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      while (b_dev_stb !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      total++; if (n >= 100) begin bad++; $display("FAIL b_poll_wait: got %0d cycles want <100", n); end
      hi = 0; ok = 1'b1;
      while (b_dev_stb === 1'b1 && hi < 20) begin
         if (b_dev_addr !== 1'b0 || b_dev_we !== 1'b0) ok = 1'b0;
         hi++; @(negedge clk);
      end
      lo = 0;
      while (b_dev_stb === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
      total++; if (hi !== 4) begin bad++; $display("FAIL poll_hold: got %0d want 4", hi); end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL poll_stable: got %b want 1", ok); end
      total++; if (lo !== 5) begin bad++; $display("FAIL poll_gap: got %0d want 5", lo); end

      @(posedge clk); #1; b_val = 8'h3A; b_load = 1'b1;
      @(posedge clk); #1; b_load = 1'b0; b_addr = 1'b0;
      n = 0;
      while (b_dout[0] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      total++; if (n >= 100) begin bad++; $display("FAIL b_first_char: got %0d cycles want <100", n); end
      b_val = 8'h3B; b_load = 1'b1;
      @(posedge clk); #1; b_load = 1'b0;
      n = 0;
      while (!(b_dev_stb === 1'b1 && b_dev_addr === 1'b1) && n < 100) begin @(posedge clk); #1; n++; end
      total++; if (n >= 100) begin bad++; $display("FAIL b_read_wait: got %0d cycles want <100", n); end
      @(posedge clk); #1;
      total++; if ({b_dev_stb, b_dev_addr} !== 2'b11) begin bad++; $display("FAIL read_hold: got %b want 11", {b_dev_stb, b_dev_addr}); end
      b_rst = 1'b1;
      @(posedge clk); #1;
      total++; if (b_dev_stb !== 1'b0) begin bad++; $display("FAIL rst_stb_drop: got %b want 0", b_dev_stb); end
      b_addr = 1'b0; #1;
      total++; if (b_dout !== 8'h00) begin bad++; $display("FAIL rst_flush_status: got %h want 00", b_dout); end
      b_addr = 1'b1; #1;
      total++; if (b_dout !== 8'h00) begin bad++; $display("FAIL rst_flush_data: got %h want 00", b_dout); end
      b_rst = 1'b0; b_addr = 1'b0;
      @(posedge clk); #1;
      total++; if ({b_dev_stb, b_dev_we, b_dev_addr, b_dev_wdata} !== 11'h600) begin
         bad++; $display("FAIL restart_init: got %h want 600", {b_dev_stb, b_dev_we, b_dev_addr, b_dev_wdata}); end
   endtask

   initial begin
      test_reset;
      test_char;
      test_irq;
      test_overflow;
      test_full_push_pop;
      test_empty_push_pop;
      test_back_to_back_delayed;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
